fp16_decoder: RTL and testbench



---
 rtl/fp16_decoder.sv | 131 +++++++++++++
 tb/tb_fp16_decoder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/fp16_decoder.sv
// rtl/fp16_decoder.sv - binary16 to signed 16-bit integer converter (truncate toward zero)
// Serial shifter aligns the magnitude one bit per clock.
module fp16_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] dataIn,
    input  logic        R_I,
    output logic [15:0] dataOut,
    output logic        R_O,
    output logic        REG_ERROR,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, UNPACK, SHIFT, SIGN, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] opnd_q, opnd_d;
    logic [15:0] mag_q, mag_d;
    logic [3:0]  k_q, k_d;
    logic        left_q, left_d;
    logic        err_q, err_d;
    logic [15:0] dout_q, dout_d;
    logic        r_o_q, r_o_d;
    logic        reg_err_q, reg_err_d;

    logic [4:0]  exp_w;
    logic [9:0]  frac_w;
    logic        sign_w;

    assign exp_w  = opnd_q[14:10];
    assign frac_w = opnd_q[9:0];
    assign sign_w = opnd_q[15];

    always_comb begin
        state_d   = state_q;
        opnd_d    = opnd_q;
        mag_d     = mag_q;
        k_d       = k_q;
        left_d    = left_q;
        err_d     = err_q;
        dout_d    = dout_q;
        r_o_d     = 1'b0;
        reg_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (R_I) begin
                    opnd_d  = dataIn;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                mag_d  = 16'h0000;
                k_d    = 4'd0;
                left_d = 1'b0;
                err_d  = 1'b0;
                // Biased exponent 15..24 needs right alignment, 25..29 left alignment.
                if (exp_w == 5'd31) begin
                    err_d = 1'b1;
                end else if (exp_w >= 5'd15 && exp_w <= 5'd24) begin
                    mag_d = {5'b00000, 1'b1, frac_w};
                    k_d   = 4'(5'd25 - exp_w);
                end else if (exp_w >= 5'd25 && exp_w <= 5'd29) begin
                    mag_d  = {5'b00000, 1'b1, frac_w};
                    k_d    = 4'(exp_w - 5'd25);
                    left_d = 1'b1;
                end else if (exp_w == 5'd30) begin
                    if (sign_w && frac_w == 10'd0) begin
                        mag_d  = 16'h0400;
                        k_d    = 4'd5;
                        left_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                state_d = (k_d != 4'd0) ? SHIFT : SIGN;
            end
            SHIFT: begin
                mag_d = left_q ? {mag_q[14:0], 1'b0} : {1'b0, mag_q[15:1]};
                k_d   = k_q - 4'd1;
                if (k_q == 4'd1) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (err_q) begin
                    mag_d = 16'h0000;
                end else if (sign_w) begin
                    mag_d = ~mag_q + 16'd1;
                end
                state_d = DONE;
            end
            DONE: begin
                dout_d    = mag_q;
                r_o_d     = 1'b1;
                reg_err_d = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            opnd_q    <= 16'h0000;
            mag_q     <= 16'h0000;
            k_q       <= 4'd0;
            left_q    <= 1'b0;
            err_q     <= 1'b0;
            dout_q    <= 16'h0000;
            r_o_q     <= 1'b0;
            reg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            opnd_q    <= opnd_d;
            mag_q     <= mag_d;
            k_q       <= k_d;
            left_q    <= left_d;
            err_q     <= err_d;
            dout_q    <= dout_d;
            r_o_q     <= r_o_d;
            reg_err_q <= reg_err_d;
        end
    end

    assign dataOut   = dout_q;
    assign R_O       = r_o_q;
    assign REG_ERROR = reg_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_fp16_decoder.sv
// tb/tb_fp16_decoder.sv - scoreboard bench for fp16_decoder with a real-arithmetic model
module tb_fp16_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] dataIn = 16'h0000;
    logic        R_I = 1'b0;
    logic [15:0] dataOut;
    logic        R_O;
    logic        REG_ERROR;
    logic        busy;

    fp16_decoder dut (
        .clk(clk), .reset(reset), .dataIn(dataIn), .R_I(R_I),
        .dataOut(dataOut), .R_O(R_O), .REG_ERROR(REG_ERROR), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] r;
        bit          err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [15:0] last_exp = 16'h0000;
    bit          mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Value-level reference: evaluate the float, truncate, range-check.
    task automatic model(input logic [15:0] x, output logic [15:0] r, output bit err, output int k);
        int  e, ee;
        real v;
        e = int'(x[14:10]);
        r = 16'h0000; err = 1'b0; k = 0;
        if (e == 31) begin
            err = 1'b1;
        end else if (e != 0) begin
            ee = e - 15;
            v = 1.0 + real'(x[9:0]) / 1024.0;
            if (ee >= 0) for (int i = 0; i < ee; i++) v = v * 2.0;
            else for (int i = 0; i < -ee; i++) v = v / 2.0;
            if (x[15]) v = -v;
            if (v >= 32768.0 || v < -32768.0) begin
                err = 1'b1;
            end else begin
                r = 16'($rtoi(v));
                k = (ee < 0) ? 0 : (ee <= 9) ? 10 - ee : ee - 10;
            end
        end
    endtask

    task automatic push(input logic [15:0] x);
        exp_t t;
        int   k;
        model(x, t.r, t.err, k);
        t.due = cyc + 4 + k;
        sb.push_back(t);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (REG_ERROR && !R_O) chk("err_without_ro", 1, 0);
            if (R_O) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ro", 1, 0);
                end else begin
                    exp_t t;
                    t = sb.pop_front();
                    chk("data", int'(dataOut), int'(t.r));
                    chk("reg_error", int'(REG_ERROR), int'(t.err));
                    chk("latency", cyc, t.due);
                    last_exp = t.r;
                end
            end else begin
                chk("hold", int'(dataOut), int'(last_exp));
            end
        end
    end

    task automatic issue(input logic [15:0] x);
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (busy) chk("idle_timeout", 1, 0);
        dataIn = x;
        R_I = 1'b1;
        push(x);
        @(negedge clk);
        R_I = 1'b0;
        dataIn = 16'($urandom);
        chk("busy_after_accept", int'(busy), 1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("drain_timeout", sb.size(), 0);
    endtask

    logic [15:0] directed[12] = '{16'h3C00, 16'hC500, 16'h4A40, 16'hCA40, 16'h77FF, 16'hF800,
                                  16'h7800, 16'h7C00, 16'h7E00, 16'h0001, 16'h8000, 16'h3800};

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_dataOut", int'(dataOut), 0);
        chk("reset_R_O", int'(R_O), 0);
        chk("reset_REG_ERROR", int'(REG_ERROR), 0);
        chk("reset_busy", int'(busy), 0);
        reset = 1'b0;
        mon_en = 1'b1;

        foreach (directed[i]) issue(directed[i]);
        drain();

        for (int i = 0; i < 200; i++) begin
            logic [15:0] x;
            x = 16'($urandom);
            if (i % 2 == 0) x[14:10] = 5'(10 + $urandom_range(0, 21));
            issue(x);
        end
        drain();

        // R_I held high; dataIn churns every cycle, only idle-cycle values are accepted.
        @(negedge clk);
        R_I = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if (i != 0) @(negedge clk);
            if (R_O) chk("idle_on_ro", int'(busy), 0);
            dataIn = 16'($urandom);
            if (i % 3 == 0) dataIn[14:10] = 5'(15 + $urandom_range(0, 14));
            if (!busy) push(dataIn);
        end
        @(negedge clk);
        R_I = 1'b0;
        drain();

        // Abort 0x3C01 during its shift phase.
        issue(16'h3C01);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        sb.delete();
        last_exp = 16'h0000;
        @(negedge clk);
        chk("abort_busy", int'(busy), 0);
        chk("abort_dataOut", int'(dataOut), 0);
        chk("abort_R_O", int'(R_O), 0);
        repeat (15) @(negedge clk);

        // Request coinciding with reset is dropped.
        reset = 1'b1;
        R_I = 1'b1;
        dataIn = 16'h3C00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        R_I = 1'b0;
        @(negedge clk);
        chk("reset_wins_busy", int'(busy), 0);
        repeat (6) @(negedge clk);

        issue(16'h4000);
        drain();
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
